// File: rtl/fp32_pkg.sv
// fp32_pkg
//   Shared binary32 field widths, special-value class encoding and the class
//   type. The operand FIFO and the downstream special-case fixup logic both
//   import this package.
package fp32_pkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Bit positions inside a 4-bit class nibble: {nan, inf, zero, denorm}.
  localparam int CLS_NAN  = 3;
  localparam int CLS_INF  = 2;
  localparam int CLS_ZERO = 1;
  localparam int CLS_DEN  = 0;

  typedef logic [3:0] fp_cls_t;

endpackage

// File: rtl/fp32_classify.sv
// fp32_classify
//   Combinational special-value classifier for one binary32 operand.
//   Ports:
//     val  in  32 : binary32 operand
//     cls  out  4 : {nan, inf, zero, denorm}; at most one bit set
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [FP_W-1:0] val,
  output fp_cls_t         cls
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             exp_max;
  logic             exp_zero;
  logic             man_zero;

  assign exp_f = val[FP_W-2 -: EXP_W];
  assign man_f = val[MAN_W-1:0];

  // NOTE: every signal written in an always_comb block gets a value on every
  // path (here a default first); a missed path would infer a latch.
  always_comb begin
    cls      = '0;
    exp_max  = (exp_f == EXP_MAX);
    exp_zero = (exp_f == '0);
    man_zero = (man_f == '0);
    cls[CLS_NAN]  = exp_max  && !man_zero;
    cls[CLS_INF]  = exp_max  &&  man_zero;
    cls[CLS_ZERO] = exp_zero &&  man_zero;
    cls[CLS_DEN]  = exp_zero && !man_zero;
  end

endmodule

// File: rtl/fmul_operand_fifo.sv
// fmul_operand_fifo
//   Operand-issue stage in front of the combinational binary32 multiplier.
//   Operand pairs are classified on write and buffered in a first-word-
//   fall-through circular FIFO; the head pair and its class flags feed the
//   multiplier and the special-case fixup logic.
//   Ports:
//     sysclk, rst_n     : clock, synchronous active-low reset
//     in_valid/in_ready : upstream handshake, in_ready = (count < DEPTH)
//     in_a, in_b        : binary32 operands
//     out_valid/out_ready : downstream handshake, out_valid = (count != 0)
//     op_a, op_b        : head operands (0 when empty)
//     op_cls            : [7:4] class of A, [3:0] class of B (0 when empty)
//     count             : occupancy 0..DEPTH
module fmul_operand_fifo
  import fp32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FP_W
) (
  input  logic                       sysclk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           op_a,
  output logic [WIDTH-1:0]           op_b,
  output logic [7:0]                 op_cls,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    fp_cls_t          cls_a;
    fp_cls_t          cls_b;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           wr_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  fp_cls_t          cls_a, cls_b;

  fp32_classify u_cls_a (.val(in_a), .cls(cls_a));
  fp32_classify u_cls_b (.val(in_b), .cls(cls_b));

  always_comb begin
    // Handshake flags come only from registered occupancy, so there is no
    // combinational path from in_valid/out_ready to in_ready/out_valid.
    in_ready  = (count_q < CNT_W'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;

    wr_entry = '{a: in_a, b: in_b, cls_a: cls_a, cls_b: cls_b};

    // DEPTH is a power of two, so plain pointer increments wrap modulo DEPTH.
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; emptiness is carried by count_q
  // and stale words are masked at the output, so resetting it buys nothing.
  always_ff @(posedge sysclk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Head presentation: forced to zero while empty so the multiplier sees
  // +0 x +0 rather than whatever stale word sits at the read pointer.
  always_comb begin
    head   = mem_q[rd_ptr_q];
    op_a   = '0;
    op_b   = '0;
    op_cls = '0;
    if (out_valid) begin
      op_a   = head.a;
      op_b   = head.b;
      op_cls = {head.cls_a, head.cls_b};
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fmul_operand_fifo.sv
module tb_fmul_operand_fifo;

  localparam int DEPTH = 4;

  logic        sysclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [7:0]  op_cls;
  logic [2:0]  count;

  // Expected class of the pair currently driven on in_a/in_b (hand-computed).
  logic [7:0]  exp_cls = '0;

  fmul_operand_fifo #(.DEPTH(DEPTH), .WIDTH(32)) dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_cls   (op_cls),
    .count    (count)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  cls;
  } exp_t;

  exp_t sb[$];
  int   model_cnt = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus plus the reference occupancy model.
  task automatic tick();
    bit mp, mq;
    mp = rst_n && in_valid && (model_cnt < DEPTH);
    mq = rst_n && out_ready && (model_cnt != 0);
    @(posedge sysclk);
    if (!rst_n) begin
      model_cnt = 0;
      sb.delete();
    end else begin
      if (mp) sb.push_back('{in_a, in_b, exp_cls});
      model_cnt = model_cnt + int'(mp) - int'(mq);
    end
    #1;
    check("count", 32'(count), 32'(model_cnt));
    check("in_ready", 32'(in_ready), 32'(model_cnt < DEPTH));
    check("out_valid", 32'(out_valid), 32'(model_cnt != 0));
    if (model_cnt == 0) begin
      check("empty_op_a", op_a, 32'h0);
      check("empty_op_b", op_b, 32'h0);
      check("empty_op_cls", 32'(op_cls), 32'h0);
    end
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [7:0] cls);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    exp_cls  = cls;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    exp_cls  = '0;
  endtask

  task automatic drain();
    idle_in();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    out_ready = 1'b0;
  endtask

  // Monitor: a pop happens at the coming edge whenever out_valid && out_ready
  // at the falling edge; the head must then match the scoreboard front.
  // Also checks that a stalled head holds steady across cycles.
  logic        held = 1'b0;
  logic [31:0] held_a, held_b;
  logic [7:0]  held_cls;

  always @(negedge sysclk) begin
    if (rst_n && held) begin
      check("stall_valid", 32'(out_valid), 32'h1);
      check("stall_op_a", op_a, held_a);
      check("stall_op_b", op_b, held_b);
      check("stall_op_cls", 32'(op_cls), 32'(held_cls));
    end
    held     = rst_n && out_valid && !out_ready;
    held_a   = op_a;
    held_b   = op_b;
    held_cls = op_cls;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pop_op_a", op_a, e.a);
        check("pop_op_b", op_b, e.b);
        check("pop_op_cls", 32'(op_cls), 32'(e.cls));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_count", 32'(count), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);

    // Single pair 1.0 x 2.0, then pop
    offer(32'h3F800000, 32'h40000000, 8'h00);
    tick();
    idle_in();
    check("t1_op_a", op_a, 32'h3F800000);
    check("t1_op_b", op_b, 32'h40000000);
    check("t1_op_cls", 32'(op_cls), 32'h00);
    check("t1_count", 32'(count), 32'h1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_empty_valid", 32'(out_valid), 32'h0);
    check("t1_empty_op_a", op_a, 32'h0);

    // Fill to DEPTH, then offer a 5th with a simultaneous pop
    for (int i = 0; i < DEPTH; i++) begin
      offer(32'h41000000 + 32'(i), 32'h42000000 + 32'(i), 8'h00);
      tick();
    end
    check("full_count", 32'(count), 32'h4);
    check("full_in_ready", 32'(in_ready), 32'h0);
    offer(32'hDEADBEEF, 32'h3F800000, 8'h00);
    out_ready = 1'b1;
    tick();
    check("full_pop_count", 32'(count), 32'h3);
    drain();

    // Special-value classes
    offer(32'h7FC00000, 32'h7F800000, 8'h84); tick();
    check("cls_nan_inf", 32'(op_cls), 32'h84);
    offer(32'h80000000, 32'h00000001, 8'h21); tick();
    offer(32'h00400000, 32'hFF800001, 8'h18); tick();
    offer(32'h7F800000, 32'h00000000, 8'h42); tick();
    offer(32'h807FFFFF, 32'hFFFFFFFF, 8'h18); tick();
    drain();

    // Streaming: one push and one pop per cycle, pointers wrap
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      offer(32'h40400000 + 32'(i), 32'hC0000000 | 32'(i), 8'h00);
      tick();
      check("stream_count", 32'(count), 32'h1);
    end
    drain();

    // Random stalls on both sides
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1)
        offer({1'b0, 8'h80, 23'(i)}, {1'b1, 8'h7E, 23'(i * 3)}, 8'h00);
      else
        idle_in();
      out_ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    drain();

    // Reset with three entries queued; handshakes in the reset cycle ignored
    for (int i = 0; i < 3; i++) begin
      offer(32'h3F000000 + 32'(i), 32'h3E000000 + 32'(i), 8'h00);
      tick();
    end
    check("pre_rst_count", 32'(count), 32'h3);
    rst_n = 1'b0;
    offer(32'h12345678, 32'h9ABCDEF0, 8'h00);
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    idle_in();
    out_ready = 1'b0;
    check("post_rst_count", 32'(count), 32'h0);
    check("post_rst_valid", 32'(out_valid), 32'h0);
    check("post_rst_in_ready", 32'(in_ready), 32'h1);
    offer(32'h40A00000, 32'h40C00000, 8'h00);
    tick();
    idle_in();
    check("post_rst_op_a", op_a, 32'h40A00000);
    drain();
    check("post_rst_empty", 32'(out_valid), 32'h0);
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
